// File: rtl/wb_slave_ram.sv
// wb_slave_ram: Wishbone single-port RAM slave with wait states, address decode and burst beats.
// Define WB_SLAVE_RAM_RTY_EN to add a post-write busy window answered with retry.
module wb_slave_ram #(
    parameter int          DEPTH_LOG2  = 8,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          BUSY_CYCLES = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] s_dat_i,
    output logic [31:0] s_dat_o,
    input  logic [31:0] s_adr_i,
    input  logic [3:0]  s_sel_i,
    input  logic        s_we_i,
    input  logic        s_cyc_i,
    input  logic        s_stb_i,
    input  logic        s_cab_i,
    output logic        s_ack_o,
    output logic        s_err_o,
    output logic        s_rty_o
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP, GAP} state_t;
    state_t state, state_nx;
    logic [31:0] mem [0:2**DEPTH_LOG2-1];
    logic [DEPTH_LOG2-1:0] idx_q, idx;
    logic [3:0] sel_q, sel;
    logic [31:0] dat_q, wdat;
    logic we_q, we;
    logic [2:0] wcnt;
    logic req, hit, busy, load, go_ack, go_err, go_rty;
    logic unused_lsb;
    assign unused_lsb = ^s_adr_i[1:0];
    assign req = s_cyc_i & s_stb_i;
    assign hit = s_adr_i[31:DEPTH_LOG2+2] == BASE_ADDR[31:DEPTH_LOG2+2];
    // The beat being answered comes from the latch only while waiting; otherwise straight from the bus
    assign idx  = (state == WAIT) ? idx_q : s_adr_i[DEPTH_LOG2+1:2];
    assign sel  = (state == WAIT) ? sel_q : s_sel_i;
    assign wdat = (state == WAIT) ? dat_q : s_dat_i;
    assign we   = (state == WAIT) ? we_q  : s_we_i;

`ifdef WB_SLAVE_RAM_RTY_EN
    logic [3:0] busy_cnt;
    assign busy = busy_cnt != 4'd0;
    always_ff @(posedge clk_i) begin
        if (rst_i) busy_cnt <= 4'd0;
        else if (go_ack && we) busy_cnt <= 4'(BUSY_CYCLES);
        else if (busy) busy_cnt <= busy_cnt - 4'd1;
    end
`else
    assign busy = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        load = 1'b0;
        go_ack = 1'b0;
        go_err = 1'b0;
        go_rty = 1'b0;
        case (state)
            IDLE: if (req) begin
                load = 1'b1;
                go_err = !hit;
                go_rty = hit && busy;
                go_ack = hit && !busy && WAIT_STATES == 0;
                state_nx = (hit && !busy && WAIT_STATES != 0) ? WAIT : RESP;
            end
            WAIT: if (!s_cyc_i) state_nx = IDLE;
                  else if (wcnt == 3'd1) begin
                      go_ack = 1'b1;
                      state_nx = RESP;
                  end
            RESP: state_nx = GAP;
            GAP: if (req && s_cab_i) begin
                go_ack = hit;
                go_err = !hit;
                state_nx = RESP;
            end else state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            wcnt <= 3'd0;
            s_ack_o <= 1'b0;
            s_err_o <= 1'b0;
            s_rty_o <= 1'b0;
            s_dat_o <= 32'd0;
        end else begin
            state <= state_nx;
            wcnt <= load ? 3'(WAIT_STATES) : (state == WAIT ? wcnt - 3'd1 : 3'd0);
            s_ack_o <= go_ack;
            s_err_o <= go_err;
            s_rty_o <= go_rty;
            s_dat_o <= (go_ack && !we) ? mem[idx] : 32'd0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (load) begin
            idx_q <= s_adr_i[DEPTH_LOG2+1:2];
            sel_q <= s_sel_i;
            dat_q <= s_dat_i;
            we_q <= s_we_i;
        end
    end

    // Contents survive reset; a write landing on a reset edge is dropped
    always_ff @(posedge clk_i) begin
        if (go_ack && we && !rst_i)
            for (int b = 0; b < 4; b++)
                if (sel[b]) mem[idx][8*b +: 8] <= wdat[8*b +: 8];
    end
endmodule

// File: doc/wb_slave_ram.md
WB_SLAVE_RAM -- requirements
Module: wb_slave_ram

Interface
REQ-001 Parameter DEPTH_LOG2, default 8, word-address width (2^DEPTH_LOG2 32-bit words) — SHALL be honoured.
REQ-002 Parameter WAIT_STATES, default 1, range 0..7, extra cycles before first-beat response — SHALL be honoured.
REQ-003 Parameter BASE_ADDR, default 32'h0000_0000, region base aligned to 2^(DEPTH_LOG2+2) — SHALL be honoured.
REQ-004 Parameter BUSY_CYCLES, default 4, range 1..15, post-write busy window (used only with REQ-025) — SHALL be honoured.
REQ-005 One clock; reset is synchronous and active-high — SHALL hold.
REQ-006 Ports SHALL be, clock and reset first:
 clk_i input 1 system clock, all logic on rising edge
 rst_i input 1 synchronous active-high reset
 s_dat_i input 32 write data
 s_dat_o output 32 read data
 s_adr_i input 32 byte address
 s_sel_i input 4 byte-lane enables, bit n = dat[8n+7:8n]
 s_we_i input 1 1=write, 0=read
 s_cyc_i input 1 bus cycle valid
 s_stb_i input 1 strobe
 s_cab_i input 1 consecutive-address burst hint
 s_ack_o output 1 normal termination
 s_err_o output 1 error termination
 s_rty_o output 1 retry termination

Function
REQ-007 FSM states SHALL be IDLE, WAIT, RESP, GAP; ack/err/rty SHALL be registered and asserted only in RESP.
REQ-008 IDLE: sampled s_cyc_i&s_stb_i SHALL latch adr/we/sel/dat and go to WAIT if WAIT_STATES>0, else RESP.
REQ-009 WAIT SHALL last exactly WAIT_STATES cycles (down-counter), then RESP; single-access latency from first sampling edge to ack high = WAIT_STATES+1 cycles.
REQ-010 RESP SHALL last exactly one cycle, asserting exactly one of ack/err/rty; next state GAP.
REQ-011 GAP SHALL last one cycle with all terminations low; then IDLE, or, if s_cyc_i&s_stb_i&s_cab_i sampled in GAP, latch new beat and go directly to RESP (burst beats skip wait states, one beat per 2 cycles).
REQ-012 In-range: s_adr_i[31:DEPTH_LOG2+2] equals BASE_ADDR[31:DEPTH_LOG2+2]; word index = s_adr_i[DEPTH_LOG2+1:2]; s_adr_i[1:0] ignored.
REQ-013 Out-of-range access SHALL skip WAIT, give s_err_o in RESP, leave memory unchanged, s_dat_o = 0.
REQ-014 Write SHALL update only lanes with s_sel_i set, on the clock edge entering RESP; s_sel_i=0 SHALL ack with no change.
REQ-015 Read SHALL place the full word on s_dat_o during RESP regardless of s_sel_i; s_dat_o SHALL be 0 outside RESP.
REQ-016 s_cyc_i low in WAIT or GAP SHALL abort to IDLE next cycle, no write, no termination.
REQ-017 s_stb_i low with s_cyc_i high in WAIT SHALL not abort; access completes.
REQ-018 Read-after-write to the same word SHALL return the new data.

Reset
REQ-019 rst_i high at a clock edge SHALL force IDLE, clear counters, and drive s_ack_o/s_err_o/s_rty_o/s_dat_o to 0 the following cycle, including mid-WAIT or mid-burst.
REQ-020 A write whose RESP-entry edge coincides with rst_i SHALL NOT update memory.
REQ-021 Memory contents SHALL NOT be reset; unwritten words read X.
REQ-022 First strobe accepted on the first edge with rst_i low.

Configuration
REQ-023 Macro WB_SLAVE_RAM_RTY_EN SHALL select the busy/retry feature.
REQ-024 Undefined: no busy counter; s_rty_o constant 0.
REQ-025 Defined: each write ack loads busy counter with BUSY_CYCLES; it decrements every cycle to 0; a strobe sampled in IDLE while nonzero SHALL skip WAIT, give s_rty_o in RESP, no memory access; reads and writes both retried.

Verification
REQ-026 WAIT_STATES=1: write 0xDEADBEEF to 0x10, sel=0xF -> ack 2 cycles after strobe sampled; read 0x10 -> s_dat_o=0xDEADBEEF with ack.
REQ-027 Write 0x11223344 to 0x20, then write 0xAABBCCDD sel=0x5 -> read returns 0x11BB33DD.
REQ-028 DEPTH_LOG2=8: access 0x400 -> err pulse 1 cycle after sampling, ack never, 0x000 unchanged.
REQ-029 Burst 4 reads from 0x0, cab=1 -> first ack at WAIT_STATES+1, then acks every 2nd cycle, data matches preloaded words.
REQ-030 cyc dropped in WAIT of write to 0x8 -> no ack, readback shows old value; rst_i pulsed mid-WAIT -> outputs 0 next cycle.
REQ-031 WB_SLAVE_RAM_RTY_EN, BUSY_CYCLES=4: write, then strobe 1 cycle after ack -> rty, no access; strobe 5 cycles after -> ack; undefined -> s_rty_o never 1.
